can_tx_framer: RTL

Transmit-side CAN frame serializer for the CAN node. It latches a request, builds the frame, computes CRC-15, inserts stuff bits and drives `txd` one bit per clock. While the ID field is on the bus it raises `arbitration_start` for the existing arbitration block, and it also checks bus readback itself. It backs off on arbitration loss, aborts on bit error or missing ACK, and reports completion.

---
 rtl/can_tx_framer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/can_tx_framer.sv
// CAN transmit framer: serializes SOF/ID/CTRL/DATA/CRC/ACK/EOF with CRC-15 and
// bit stuffing, checks bus readback every bit and reports done/arb loss/error.
//
// state  | meaning
// IDLE   | bus recessive, waiting for tx_start
// SOF    | driving start-of-frame (dominant)
// ID     | driving identifier bits or ID-field stuff bits, arbitration live
// CTRL   | driving control field
// DATA   | driving {rw, addr, data, 14'b0}
// CRC    | driving frozen CRC-15, including a trailing stuff bit
// ACK    | driving recessive, expecting a dominant acknowledge
// EOF    | driving recessive end bit, then report completion
module can_tx_framer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        tx_start,
  input  logic [10:0] tx_id,
  input  logic [6:0]  tx_ctrl,
  input  logic        tx_rw,
  input  logic [14:0] tx_addr,
  input  logic [15:0] tx_data,
  input  logic        rxd,
  output logic        txd,
  output logic        arbitration_start,
  output logic        busy,
  output logic        tx_done,
  output logic        arb_lost,
  output logic        tx_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_ID, S_CTRL, S_DATA, S_CRC, S_ACK, S_EOF
  } state_t;

  localparam logic [14:0] CRC_POLY = 15'h4599;

  state_t      state_q, state_d;
  logic [63:0] sreg_q, sreg_d;
  logic [14:0] crc_q, crc_d;
  logic [6:0]  pos_q, pos_d;
  logic [2:0]  run_q, run_d;
  logic        txd_q, txd_d;
  logic        arb_q, arb_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        lost_q, lost_d;
  logic        err_q, err_d;

  logic        mismatch;
  logic        stuff_due;
  logic        abort;
  logic [6:0]  pos_nxt;
  state_t      fld_nxt;
  logic        bit_nxt;

  // Field that owns unstuffed frame bit position pos (SOF is position 0).
  function automatic state_t field_of(input logic [6:0] pos);
    if (pos == 7'd0)       return S_SOF;
    else if (pos < 7'd12)  return S_ID;
    else if (pos < 7'd19)  return S_CTRL;
    else if (pos < 7'd65)  return S_DATA;
    else if (pos < 7'd80)  return S_CRC;
    else if (pos == 7'd80) return S_ACK;
    else                   return S_EOF;
  endfunction

  function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[14];
    return {crc[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'd0);
  endfunction

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    crc_d     = crc_q;
    pos_d     = pos_q;
    run_d     = run_q;
    txd_d     = txd_q;
    done_d    = 1'b0;
    lost_d    = 1'b0;
    err_d     = 1'b0;
    abort     = 1'b0;
    bit_nxt   = 1'b1;
    pos_nxt   = pos_q + 7'd1;
    fld_nxt   = field_of(pos_nxt);
    mismatch  = rxd ^ txd_q;
    stuff_due = (state_q inside {S_SOF, S_ID, S_CTRL, S_DATA, S_CRC}) && (run_q == 3'd5);

    // rxd is the bus value of the bit currently held in txd_q
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (tx_start) begin
          sreg_d  = {tx_id, tx_ctrl, tx_rw, tx_addr, tx_data, 14'd0};
          crc_d   = 15'd0;
          pos_d   = 7'd0;
          run_d   = 3'd1;
          txd_d   = 1'b0;
          state_d = S_SOF;
        end
      end
      S_ID: begin
        if (mismatch) begin
          abort  = 1'b1;
          lost_d = txd_q;
          err_d  = ~txd_q;
        end
      end
      S_SOF, S_CTRL, S_DATA, S_CRC: begin
        if (mismatch) begin
          abort = 1'b1;
          err_d = 1'b1;
        end
      end
      S_ACK: begin
        if (rxd) begin
          abort = 1'b1;
          err_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (state_q != S_IDLE) begin
      if (abort) begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end else if (state_q == S_EOF) begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        done_d  = 1'b1;
      end else if (stuff_due) begin
        // stuff bit stays in the current field and does not advance pos
        txd_d = ~txd_q;
        run_d = 3'd1;
      end else begin
        case (fld_nxt)
          S_ID, S_CTRL, S_DATA: begin
            bit_nxt = sreg_q[63];
            sreg_d  = {sreg_q[62:0], 1'b0};
            crc_d   = crc_step(crc_q, bit_nxt);
          end
          S_CRC: begin
            bit_nxt = crc_q[14];
            crc_d   = {crc_q[13:0], 1'b0};
          end
          default: bit_nxt = 1'b1;
        endcase
        state_d = fld_nxt;
        pos_d   = pos_nxt;
        txd_d   = bit_nxt;
        run_d   = (bit_nxt == txd_q) ? run_q + 3'd1 : 3'd1;
      end
    end

    busy_d = (state_d != S_IDLE);
    arb_d  = (state_d == S_ID);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      crc_q   <= '0;
      pos_q   <= '0;
      run_q   <= '0;
      txd_q   <= 1'b1;
      arb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lost_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      crc_q   <= crc_d;
      pos_q   <= pos_d;
      run_q   <= run_d;
      txd_q   <= txd_d;
      arb_q   <= arb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lost_q  <= lost_d;
      err_q   <= err_d;
    end
  end

  assign txd               = txd_q;
  assign arbitration_start = arb_q;
  assign busy              = busy_q;
  assign tx_done           = done_q;
  assign arb_lost          = lost_q;
  assign tx_error          = err_q;

endmodule
